io_stream_unit: RTL and testbench

Parametrised successor to the accelerator's IO path. It accepts run-length-encoded tokens from the host one section at a time and expands them into full decompressed rows. It delivers a programmable number of rows to the CNN or image buffer over a valid/ready handshake and signals completion. It merges the interface, decompressor and controller roles into one sequential block, adding back-pressure, runs that span rows, and row counting.

---
 rtl/io_stream_unit.sv | 152 +++++++++++++++
 tb/tb_io_stream_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stream_unit.sv
// Run-length token expander: turns host RLE tokens into ROW_SIZE-bit rows and streams
// a programmed number of rows downstream. Optional raw-token mode: IO_STREAM_RAW_BYPASS_EN.
module io_stream_unit #(
    parameter int SECTION_SIZE = 4,
    parameter int ROW_SIZE     = 16,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    cnn_img,
    input  logic [CNT_W-1:0]        row_count,
`ifdef IO_STREAM_RAW_BYPASS_EN
    input  logic                    raw_mode,
`endif
    input  logic                    interrupt,
    input  logic [SECTION_SIZE-1:0] inputSection,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_SIZE-1:0]     decompressedData,
    output logic                    out_dest,
    output logic                    done,
    output logic                    overrun,
    output logic [1:0]              state_dbg
);

    // Handshakes: a token moves when interrupt && in_ready, a row moves when
    // out_valid && out_ready, both on the rising edge; producers hold until taken.

    localparam int FW = $clog2(ROW_SIZE + 1);
    localparam int RW = SECTION_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [FW-1:0]       fill_cnt;
    logic                run_bit;
    logic [RW-1:0]       run_left;
    logic [CNT_W-1:0]    rows_left;
    logic [ROW_SIZE-1:0] row;
    logic                raw_q;

    logic                accept;
    logic                act_bit;
    logic [FW-1:0]       act_len;
    logic [FW-1:0]       space;
    logic [FW-1:0]       n;
    logic [FW-1:0]       fill_next;
    logic [RW-1:0]       run_next;
    logic [ROW_SIZE-1:0] row_next;
    logic [ROW_SIZE-1:0] raw_mask;

    assign in_ready         = (state == FILL) && (run_left == '0);
    assign accept           = interrupt && in_ready;
    assign out_valid        = (state == EMIT);
    assign done             = (state == DONE);
    assign overrun          = (state == DONE) && (run_left != '0);
    assign decompressedData = row;
    assign state_dbg        = state;

    // A pending run always takes priority; in_ready is low while one exists.
    always_comb begin
        act_bit  = run_bit;
        act_len  = '0;
        raw_mask = '0;
        if (run_left != '0) begin
            act_len = FW'(run_left);
        end else if (accept) begin
            act_bit = inputSection[SECTION_SIZE-1];
            act_len = FW'(inputSection[SECTION_SIZE-2:0]) + FW'(1);
        end
        space     = FW'(ROW_SIZE) - fill_cnt;
        n         = (act_len < space) ? act_len : space;
        run_next  = RW'(act_len - n);
        fill_next = fill_cnt + n;
        row_next  = row;
        for (int i = 0; i < ROW_SIZE; i++) begin
            if ((FW'(i) >= fill_cnt) && (FW'(i) < fill_next)) begin
                row_next[i] = act_bit;
            end
        end
        if (raw_q) begin
            run_next  = '0;
            fill_next = fill_cnt;
            row_next  = row;
            if (accept) begin
                raw_mask  = ROW_SIZE'({SECTION_SIZE{1'b1}}) << fill_cnt;
                row_next  = (row & ~raw_mask) | (ROW_SIZE'(inputSection) << fill_cnt);
                fill_next = fill_cnt + FW'(SECTION_SIZE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            run_bit   <= 1'b0;
            run_left  <= '0;
            rows_left <= '0;
            row       <= '0;
            out_dest  <= 1'b0;
            raw_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        out_dest  <= cnn_img;
                        rows_left <= row_count;
                        fill_cnt  <= '0;
                        run_left  <= '0;
`ifdef IO_STREAM_RAW_BYPASS_EN
                        raw_q     <= raw_mode;
`else
                        raw_q     <= 1'b0;
`endif
                        state     <= (row_count == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    row      <= row_next;
                    fill_cnt <= fill_next;
                    run_left <= run_next;
                    run_bit  <= act_bit;
                    if (fill_next == FW'(ROW_SIZE)) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    // run_left is left untouched so a spanning run continues in the next row.
                    if (out_ready) begin
                        fill_cnt  <= '0;
                        rows_left <= rows_left - CNT_W'(1);
                        state     <= (rows_left == CNT_W'(1)) ? DONE : FILL;
                    end
                end
                DONE: begin
                    run_left <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_stream_unit.sv
// Scoreboard bench for io_stream_unit: directed RLE token sequences with
// hand-computed rows, monitor-side comparison of every row and done pulse.
module tb_io_stream_unit;

    localparam int SS = 4;
    localparam int RS = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          cnn_img = 1'b0;
    logic [CW-1:0] row_count = '0;
    logic          raw_mode = 1'b0;
    logic          interrupt = 1'b0;
    logic [SS-1:0] inputSection = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RS-1:0] decompressedData;
    logic          out_dest;
    logic          done;
    logic          overrun;
    logic [1:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_target = 0;
    logic prev_done = 1'b0;

    logic [RS:0] exp_q[$];       // {dest, row}
    logic        exp_done_q[$];  // expected overrun per done pulse

    io_stream_unit #(.SECTION_SIZE(SS), .ROW_SIZE(RS), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .cnn_img(cnn_img),
        .row_count(row_count),
`ifdef IO_STREAM_RAW_BYPASS_EN
        .raw_mode(raw_mode),
`endif
        .interrupt(interrupt),
        .inputSection(inputSection),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .decompressedData(decompressedData),
        .out_dest(out_dest),
        .done(done),
        .overrun(overrun),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: samples just after the falling edge, when inputs for the next edge are settled.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", {15'd0, out_dest, decompressedData}, 32'hFFFF_FFFF);
                end else begin
                    logic [RS:0] e;
                    e = exp_q.pop_front();
                    check("row_data", {16'd0, decompressedData}, {16'd0, e[RS-1:0]});
                    check("row_dest", {31'd0, out_dest}, {31'd0, e[RS]});
                end
            end
            if (done) begin
                done_cnt++;
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic eo;
                    eo = exp_done_q.pop_front();
                    check("overrun", {31'd0, overrun}, {31'd0, eo});
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic do_load(input logic [CW-1:0] rows, input logic dest);
        @(negedge clk);
        load = 1'b1;
        row_count = rows;
        cnn_img = dest;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic send_token(input logic [SS-1:0] tok);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        interrupt = 1'b1;
        inputSection = tok;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        interrupt = 1'b0;
        if (!ok) check("token_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_row(input logic dest, input logic [RS-1:0] data);
        exp_q.push_back({dest, data});
    endtask

    task automatic expect_done(input logic ov);
        exp_done_q.push_back(ov);
        done_target++;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #2;
            if (done_cnt >= done_target) ok = 1'b1;
        end
        if (!ok) check("done_timeout", done_cnt, done_target);
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_done", {30'd0, done, overrun}, 32'd0);
            check("rst_data", {15'd0, out_dest, decompressedData}, 32'd0);
        end

        // Single row: 8 ones then 8 zeros
        expect_row(1'b1, 16'h00FF);
        expect_done(1'b0);
        do_load(8'd1, 1'b1);
        send_token(4'b1111);
        send_token(4'b0111);
        wait_done();

        // Two rows of aligned 8-bit runs
        expect_row(1'b0, 16'hFF00);
        expect_row(1'b0, 16'h00FF);
        expect_done(1'b0);
        do_load(8'd2, 1'b0);
        send_token(4'b0111);
        send_token(4'b1111);
        send_token(4'b1111);
        send_token(4'b0111);
        wait_done();

        // Run of 6 ones spanning the row boundary (3 + 3)
        expect_row(1'b1, 16'hE0FF);
        expect_row(1'b1, 16'hF807);
        expect_done(1'b0);
        do_load(8'd2, 1'b1);
        send_token(4'b1111);
        send_token(4'b0100);
        send_token(4'b1101);
        send_token(4'b0111);
        send_token(4'b1100);
        wait_done();

        // Back-pressure: row held 5 cycles while a token is offered
        expect_row(1'b0, 16'hFFFF);
        expect_row(1'b0, 16'h00FF);
        expect_done(1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        do_load(8'd2, 1'b0);
        send_token(4'b1111);
        send_token(4'b1111);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                #2;
                seen = out_valid;
            end
            check("bp_valid_seen", {31'd0, seen}, 32'd1);
        end
        interrupt = 1'b1;
        inputSection = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            check("bp_valid_held", {31'd0, out_valid}, 32'd1);
            check("bp_data_held", {16'd0, decompressedData}, 32'h0000_FFFF);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        interrupt = 1'b0;
        send_token(4'b1111);
        send_token(4'b0111);
        wait_done();

        // Overrun: final run leaves 3 bits unused
        expect_row(1'b1, 16'hE0FF);
        expect_done(1'b1);
        do_load(8'd1, 1'b1);
        send_token(4'b1111);
        send_token(4'b0100);
        send_token(4'b1101);
        wait_done();

        // Leftover must not leak into the next transfer
        expect_row(1'b0, 16'h0000);
        expect_done(1'b0);
        do_load(8'd1, 1'b0);
        send_token(4'b0111);
        send_token(4'b0111);
        wait_done();

        // Zero row count: done with no row
        expect_done(1'b0);
        do_load(8'd0, 1'b1);
        wait_done();

        // Abort mid-FILL
        do_load(8'd1, 1'b1);
        send_token(4'b1111);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_done", {30'd0, done, overrun}, 32'd0);
        check("abort_data", {15'd0, out_dest, decompressedData}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_row(1'b0, 16'h00F0);
        expect_done(1'b0);
        do_load(8'd1, 1'b0);
        send_token(4'b0011);
        send_token(4'b1011);
        send_token(4'b0111);
        wait_done();

        repeat (3) @(negedge clk);
        check("rows_outstanding", exp_q.size(), 32'd0);
        check("dones_outstanding", exp_done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
